// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock period meter.
// State encoding plus default counter and synchronizer sizes.
package clkdiv_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } state_e;

endpackage

// File: rtl/sig_edge_detect.sv
// Synchronizer chain plus history flop for an asynchronous input.
// Both edges see identical latency, so edge-to-edge counts are exact.
module sig_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  // Fewer than two stages is not a safe synchronizer.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] r_sync;
  logic          r_hist;
  logic          w_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[NS-2:0], sig_in};
      r_hist <= r_sync[NS-1];
    end
  end

  assign w_sync = r_sync[NS-1];
  assign rise   = w_sync & ~r_hist;
  assign fall   = ~w_sync & r_hist;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in system clocks.
// Single-shot or continuous; saturation aborts with a sticky timeout.
module clk_period_meter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;

  logic w_rise, w_fall;
  logic w_load1, w_inc, w_cap_hi;
  logic w_pub, w_set_to, w_clr_to;
  logic w_at_max;

  sig_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clock (clock),
    .reset (reset),
    .sig_in(sig_in),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_at_max = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_load1     = 1'b0;
    w_inc       = 1'b0;
    w_cap_hi    = 1'b0;
    w_pub       = 1'b0;
    w_set_to    = 1'b0;
    w_clr_to    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr_to    = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (w_rise) begin
          w_load1     = 1'b1;
          w_state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_cap_hi    = 1'b1;
          w_inc       = 1'b1;
          w_state_nxt = ST_LOW;
        end else if (w_at_max) begin
          w_set_to    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_pub = 1'b1;
          // Closing rise doubles as the next opening rise.
          if (continuous) begin
            w_load1     = 1'b1;
            w_state_nxt = ST_HIGH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_at_max) begin
          w_set_to    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi_cap  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_pub;
      if (w_load1) begin
        r_cnt <= CNT_ONE;
      end else if (w_inc && !w_at_max) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_cap_hi) begin
        r_hi_cap <= r_cnt;
      end
      if (w_pub) begin
        r_period <= r_cnt;
        r_high   <= r_hi_cap;
      end
      if (w_set_to) begin
        r_timeout <= 1'b1;
      end else if (w_clr_to) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign valid    = r_valid;
  assign period   = r_period;
  assign high_cnt = r_high;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: directed waveforms,
// expected results queued at stimulus time and popped on valid.
module tb_clk_period_meter;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sig_a, start_a, cont_a;
  logic        busy_a, valid_a, to_a;
  logic [15:0] period_a, high_a;
  logic        sig_b, start_b, cont_b;
  logic        busy_b, valid_b, to_b;
  logic [3:0]  period_b, high_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nvalid_a = 0;
  int   nvalid_b = 0;
  int   vcyc[$];
  exp_t qa[$];
  exp_t qb[$];

  int   hi_len = 2;
  int   lo_len = 2;
  logic gen_en = 1'b0;

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_a (
    .clock(clk), .reset(rst_n), .sig_in(sig_a),
    .start(start_a), .continuous(cont_a),
    .busy(busy_a), .valid(valid_a), .period(period_a),
    .high_cnt(high_a), .timeout(to_a)
  );

  clk_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_b (
    .clock(clk), .reset(rst_n), .sig_in(sig_b),
    .start(start_b), .continuous(cont_b),
    .busy(busy_b), .valid(valid_b), .period(period_b),
    .high_cnt(high_b), .timeout(to_b)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) cyc++;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && valid_a) begin
      nvalid_a++;
      vcyc.push_back(cyc);
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_a: period %0d high %0d, none expected",
                 period_a, high_a);
      end else begin
        e = qa.pop_front();
        chk("period_a", 32'(period_a), 32'(e.p));
        chk("high_cnt_a", 32'(high_a), 32'(e.h));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && valid_b) begin
      nvalid_b++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_b: period %0d high %0d, none expected",
                 period_b, high_b);
      end else begin
        e = qb.pop_front();
        chk("period_b", 32'(period_b), 32'(e.p));
        chk("high_cnt_b", 32'(high_b), 32'(e.h));
      end
    end
  end

  initial begin
    sig_a = 1'b0;
    forever begin
      if (gen_en) begin
        sig_a = 1'b1;
        repeat (hi_len) @(negedge clk);
        sig_a = 1'b0;
        repeat (lo_len) @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_va(input int target, input int budget,
                         input string name);
    int n;
    n = 0;
    while (nvalid_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, nvalid_a, target);
  endtask

  task automatic set_pat(input int h, input int l);
    hi_len = h;
    lo_len = l;
    gen_en = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0;
    cont_a = 1'b0;
    start_b = 1'b0;
    cont_b = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_period", period_a, 0);
    chk("rst_high", high_a, 0);
    chk("rst_timeout", to_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single shot, 2 high / 2 low
    set_pat(2, 2);
    qa.push_back(exp_t'{16'd4, 16'd2});
    pulse_a();
    chk("busy_after_start", busy_a, 1);
    wait_va(1, 50, "valids_2_2");
    @(negedge clk);
    chk("busy_done_2_2", busy_a, 0);
    repeat (20) @(negedge clk);

    // 25% duty
    set_pat(1, 3);
    qa.push_back(exp_t'{16'd4, 16'd1});
    pulse_a();
    wait_va(2, 50, "valids_1_3");
    @(negedge clk);
    chk("busy_done_1_3", busy_a, 0);

    // repeated start while busy
    set_pat(3, 5);
    qa.push_back(exp_t'{16'd8, 16'd3});
    pulse_a();
    repeat (3) pulse_a();
    wait_va(3, 60, "valids_restart");
    repeat (30) @(negedge clk);
    chk("restart_single", nvalid_a, 3);
    chk("busy_done_restart", busy_a, 0);

    // continuous, 10 back-to-back results
    set_pat(4, 4);
    cont_a = 1'b1;
    vcyc.delete();
    for (int i = 0; i < 10; i++)
      qa.push_back(exp_t'{16'd8, 16'd4});
    pulse_a();
    wait_va(12, 200, "valids_cont9");
    @(negedge clk);
    cont_a = 1'b0;
    wait_va(13, 40, "valids_cont10");
    repeat (20) @(negedge clk);
    chk("cont_stops", nvalid_a, 13);
    chk("cont_count", vcyc.size(), 10);
    if (vcyc.size() == 10)
      chk("cont_span", vcyc[9] - vcyc[0], 72);
    chk("busy_done_cont", busy_a, 0);

    // CNT_W=4 timeout with sig held high
    pulse_b();
    @(negedge clk);
    sig_b = 1'b1;
    repeat (17) @(negedge clk);
    chk("to_b_before", to_b, 0);
    chk("busy_b_before", busy_b, 1);
    @(negedge clk);
    chk("to_b_set", to_b, 1);
    chk("busy_b_idle", busy_b, 0);
    sig_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_b_sticky", to_b, 1);
    pulse_b();
    chk("to_b_cleared", to_b, 0);
    qb.push_back(exp_t'{16'd5, 16'd2});
    @(negedge clk);
    sig_b = 1'b1;
    repeat (2) @(negedge clk);
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    sig_b = 1'b1;
    n = 0;
    while (nvalid_b < 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("valids_b", nvalid_b, 1);
    chk("to_b_normal", to_b, 0);

    // reset while in LOW
    @(negedge sig_a);
    pulse_a();
    @(posedge sig_a);
    @(negedge sig_a);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_valid", valid_a, 0);
    chk("arst_period", period_a, 0);
    chk("arst_high", high_a, 0);
    chk("arst_timeout", to_a, 0);
    chk("arst_period_b", period_b, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_valids", nvalid_a, 13);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_timeout", to_a, 0);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
